// File: rtl/fixed_decimal_pkg.sv
// Shared constants, FSM state type and sizing helper for the fixed-point
// to seven-segment decimal converter.
package fixed_decimal_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INT    = 2'd1,
        FRAC   = 2'd2,
        UPDATE = 2'd3
    } state_t;

    // Nibbles needed to hold any INT_BITS-wide unsigned value in BCD.
    function automatic int bcd_digits(input int int_bits);
        return (int_bits * 3) / 10 + 1;
    endfunction

endpackage

// File: rtl/dd_bcd_step.sv
// One double-dabble iteration: add 3 to every nibble >= 5, then shift in one bit.
module dd_bcd_step #(
    parameter int NIBBLES = 4
) (
    input  logic [4*NIBBLES-1:0] bcd,
    input  logic                 shift_bit,
    output logic [4*NIBBLES-1:0] bcd_next
);
    logic [4*NIBBLES-1:0] adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NIBBLES; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    assign bcd_next = (adj << 1) | (4*NIBBLES)'(shift_bit);
endmodule

// File: rtl/seven_segment.sv
// Active-low seven-segment decoder for one decimal digit (bit0=a .. bit6=g).
// Non-decimal codes show blank.
module seven_segment (
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'b1111111;
        case (digit)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end
endmodule

// File: rtl/fixed_decimal_display_seq.sv
// Sequential fixed-point to seven-segment decimal converter: serial double-dabble
// for the integer part, repeated x10 for the fraction, results held between runs.
module fixed_decimal_display_seq
    import fixed_decimal_pkg::*;
#(
    parameter int INT_BITS      = 12,
    parameter int FRAC_BITS     = 4,
    parameter int INT_DIGITS    = 4,
    parameter int FRAC_DIGITS   = 4,
    parameter int BLANK_LEADING = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       signed_mode,
    input  logic [INT_BITS+FRAC_BITS-1:0] val,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow,
    output logic [6:0]                 seg7_neg_sign,
    output logic [7*INT_DIGITS-1:0]    seg7_int,
    output logic [7*FRAC_DIGITS-1:0]   seg7_frac
);
    localparam int W          = INT_BITS + FRAC_BITS;
    localparam int BCD_DIGITS = bcd_digits(INT_BITS);
    localparam int CNT_MAX    = (INT_BITS > FRAC_DIGITS) ? INT_BITS : FRAC_DIGITS;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        cnt;
    logic                    neg_r;
    logic [INT_BITS-1:0]     int_sh;
    logic [4*BCD_DIGITS-1:0] bcd, bcd_nx;
    logic [FRAC_BITS+3:0]    f, f10;
    logic [4*FRAC_DIGITS-1:0] frac_bcd, frac_next;
    logic                    neg_c, ovf_c;
    logic [W-1:0]            mag_c;
    logic [3:0]              int_nib [INT_DIGITS];
    logic [6:0]              int_raw [INT_DIGITS];
    logic [7*INT_DIGITS-1:0] int_seg_nx;
    logic [7*FRAC_DIGITS-1:0] frac_seg_nx;

    assign neg_c = signed_mode & val[W-1];
    assign mag_c = neg_c ? (W'(0) - val) : val;
    assign f10   = (f << 3) + (f << 1);
    assign busy  = (state != IDLE);

    dd_bcd_step #(.NIBBLES(BCD_DIGITS)) u_dd (
        .bcd       (bcd),
        .shift_bit (int_sh[INT_BITS-1]),
        .bcd_next  (bcd_nx)
    );

    // New fraction digit enters at the top; after FRAC_DIGITS shifts tenths sits at index 0.
    if (FRAC_DIGITS > 1) begin : g_frac_multi
        assign frac_next = {f10[FRAC_BITS+3:FRAC_BITS], frac_bcd[4*FRAC_DIGITS-1:4]};
    end else begin : g_frac_single
        assign frac_next = f10[FRAC_BITS+3:FRAC_BITS];
    end

    if (BCD_DIGITS > INT_DIGITS) begin : g_ovf
        assign ovf_c = |bcd[4*BCD_DIGITS-1:4*INT_DIGITS];
    end else begin : g_no_ovf
        assign ovf_c = 1'b0;
    end

    for (genvar i = 0; i < INT_DIGITS; i++) begin : g_int
        if (i < BCD_DIGITS) begin : g_nib
            assign int_nib[i] = bcd[4*i +: 4];
        end else begin : g_zero
            assign int_nib[i] = 4'd0;
        end
        seven_segment u_seg (.digit(int_nib[i]), .seg(int_raw[i]));
    end

    for (genvar j = 0; j < FRAC_DIGITS; j++) begin : g_frac
        seven_segment u_seg (.digit(frac_bcd[4*j +: 4]), .seg(frac_seg_nx[7*j +: 7]));
    end

    always_comb begin
        logic seen;
        int_seg_nx = '1;
        seen       = 1'b0;
        for (int i = INT_DIGITS - 1; i >= 0; i--) begin
            seen = seen | (int_nib[i] != 4'd0);
            if (ovf_c)
                int_seg_nx[7*i +: 7] = SEG_DASH;
            else if ((BLANK_LEADING != 0) && (i > 0) && !seen)
                int_seg_nx[7*i +: 7] = SEG_BLANK;
            else
                int_seg_nx[7*i +: 7] = int_raw[i];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = INT;
            INT:     if (cnt == '0) state_nx = FRAC;
            FRAC:    if (cnt == '0) state_nx = UPDATE;
            UPDATE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            neg_r         <= 1'b0;
            int_sh        <= '0;
            bcd           <= '0;
            f             <= '0;
            frac_bcd      <= '0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            seg7_neg_sign <= SEG_BLANK;
            seg7_int      <= '1;
            seg7_frac     <= '1;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    neg_r  <= neg_c;
                    int_sh <= mag_c[W-1:FRAC_BITS];
                    f      <= {4'd0, mag_c[FRAC_BITS-1:0]};
                    bcd    <= '0;
                    cnt    <= CNT_W'(INT_BITS - 1);
                end
                INT: begin
                    bcd    <= bcd_nx;
                    int_sh <= int_sh << 1;
                    cnt    <= (cnt == '0) ? CNT_W'(FRAC_DIGITS - 1) : cnt - 1'b1;
                end
                FRAC: begin
                    f        <= {4'd0, f10[FRAC_BITS-1:0]};
                    frac_bcd <= frac_next;
                    cnt      <= cnt - 1'b1;
                end
                UPDATE: begin
                    done          <= 1'b1;
                    overflow      <= ovf_c;
                    seg7_neg_sign <= neg_r ? SEG_DASH : SEG_BLANK;
                    seg7_int      <= int_seg_nx;
                    seg7_frac     <= frac_seg_nx;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_decimal_display_seq.sv
// Directed bench for fixed_decimal_display_seq: default instance plus a
// three-digit instance for the overflow path.
module tb_fixed_decimal_display_seq;
    localparam logic [6:0] BLK = 7'b1111111;
    localparam logic [6:0] DSH = 7'b0111111;
    localparam int B = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        start3 = 1'b0;
    logic        signed_mode = 1'b0;
    logic [15:0] val = '0;

    logic        busy, done, overflow;
    logic [6:0]  seg7_neg_sign;
    logic [27:0] seg7_int, seg7_frac;
    logic        busy3, done3, overflow3;
    logic [6:0]  seg7_neg_sign3;
    logic [20:0] seg7_int3, seg7_frac3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fixed_decimal_display_seq dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .val(val),
        .busy(busy), .done(done), .overflow(overflow),
        .seg7_neg_sign(seg7_neg_sign), .seg7_int(seg7_int), .seg7_frac(seg7_frac)
    );

    fixed_decimal_display_seq #(.INT_DIGITS(3), .FRAC_DIGITS(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .signed_mode(signed_mode), .val(val),
        .busy(busy3), .done(done3), .overflow(overflow3),
        .seg7_neg_sign(seg7_neg_sign3), .seg7_int(seg7_int3), .seg7_frac(seg7_frac3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Digit code: 0..9 decimal, B = blank.
    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return BLK;
        endcase
    endfunction

    // Thousands first.
    function automatic logic [27:0] int4(input int d3, input int d2, input int d1, input int d0);
        return {enc(d3), enc(d2), enc(d1), enc(d0)};
    endfunction

    // Tenths first.
    function automatic logic [27:0] frac4(input int t, input int h, input int th, input int tt);
        return {enc(tt), enc(th), enc(h), enc(t)};
    endfunction

    // Launches a conversion on the default instance; lat = edges from accept to done.
    task automatic conv(input logic sm, input logic [15:0] v, output int lat);
        @(negedge clk);
        signed_mode = sm;
        val = v;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, ndone;

        #23;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_sign", seg7_neg_sign, BLK);
        check("rst_int", seg7_int, {4{BLK}});
        check("rst_frac", seg7_frac, {4{BLK}});
        @(negedge clk);
        rst = 1'b1;

        // 2047.9375
        conv(1'b1, 16'h7FFF, lat);
        check("7fff_lat", lat, 17);
        check("7fff_sign", seg7_neg_sign, BLK);
        check("7fff_int", seg7_int, int4(2, 0, 4, 7));
        check("7fff_frac", seg7_frac, frac4(9, 3, 7, 5));
        check("7fff_ovf", overflow, 1'b0);
        check("7fff_busy", busy, 1'b0);
        @(posedge clk); #1;
        check("done_pulse", done, 1'b0);
        check("hold_int", seg7_int, int4(2, 0, 4, 7));

        // -2048.0
        conv(1'b1, 16'h8000, lat);
        check("8000_lat", lat, 17);
        check("8000_sign", seg7_neg_sign, DSH);
        check("8000_int", seg7_int, int4(2, 0, 4, 8));
        check("8000_frac", seg7_frac, frac4(0, 0, 0, 0));

        // -0.0625
        conv(1'b1, 16'hFFFF, lat);
        check("ffff_s_sign", seg7_neg_sign, DSH);
        check("ffff_s_int", seg7_int, int4(B, B, B, 0));
        check("ffff_s_frac", seg7_frac, frac4(0, 6, 2, 5));

        // 4095.9375
        conv(1'b0, 16'hFFFF, lat);
        check("ffff_u_sign", seg7_neg_sign, BLK);
        check("ffff_u_int", seg7_int, int4(4, 0, 9, 5));
        check("ffff_u_frac", seg7_frac, frac4(9, 3, 7, 5));

        // 1000.0 on the three-digit instance overflows
        @(negedge clk);
        signed_mode = 1'b0;
        val = 16'h3E80;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        lat = 0;
        while (!done3 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ovf_lat", lat, 16);
        check("ovf_flag", overflow3, 1'b1);
        check("ovf_int", seg7_int3, {3{DSH}});
        check("ovf_frac", seg7_frac3, {3{enc(0)}});
        check("ovf_sign", seg7_neg_sign3, BLK);

        // second start mid-conversion is ignored
        @(negedge clk);
        signed_mode = 1'b1;
        val = 16'h7FFF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        val = 16'h8000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("ignore_ndone", ndone, 1);
        check("ignore_int", seg7_int, int4(2, 0, 4, 7));

        // reset mid-conversion
        @(negedge clk);
        signed_mode = 1'b1;
        val = 16'h8000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_sign", seg7_neg_sign, BLK);
        check("mid_rst_int", seg7_int, {4{BLK}});
        check("mid_rst_frac", seg7_frac, {4{BLK}});
        check("mid_rst_ovf3", overflow3, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // start in the done cycle is accepted
        conv(1'b0, 16'h0010, lat);
        check("b2b_lat1", lat, 17);
        check("b2b_int1", seg7_int, int4(B, B, B, 1));
        signed_mode = 1'b1;
        val = 16'hFFFF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_lat2", lat, 17);
        check("b2b_sign2", seg7_neg_sign, DSH);
        check("b2b_frac2", seg7_frac, frac4(0, 6, 2, 5));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
